// File: rtl/divider_bf16_seq.sv
// Iterative bf16 divider Q = A / B using restoring division, one quotient bit per cycle.
// Define DIVIDER_BF16_ROUND_EN for 10 quotient bits with round-to-nearest-even instead of truncation.
module divider_bf16_seq #(
  parameter logic [15:0] NAN_OUT = 16'h7F81
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Q,
  output logic        div_by_zero,
  output logic        busy
);

`ifdef DIVIDER_BF16_ROUND_EN
  localparam int unsigned NQ = 10;
`else
  localparam int unsigned NQ = 9;
`endif
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t          state_q;
  logic            sign_q;
  logic [7:0]      ea_q, eb_q, mb_q;
  logic [8:0]      rem_q;
  logic [NQ-1:0]   quo_q;
  logic [CW-1:0]   cnt_q;
  logic [15:0]     q_q;
  logic            out_valid_q, dbz_q, in_ready_q, busy_q;

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign Q           = q_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;

  // Operand classification at accept; denormals count as zero.
  logic        sign_c, a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic        spec_c, spec_dbz_c;
  logic [15:0] spec_q_c;

  always_comb begin
    sign_c     = A[15] ^ B[15];
    a_zero     = (A[14:7] == 8'h00);
    a_inf      = (A[14:7] == 8'hFF) && (A[6:0] == 7'h00);
    a_nan      = (A[14:7] == 8'hFF) && (A[6:0] != 7'h00);
    b_zero     = (B[14:7] == 8'h00);
    b_inf      = (B[14:7] == 8'hFF) && (B[6:0] == 7'h00);
    b_nan      = (B[14:7] == 8'hFF) && (B[6:0] != 7'h00);
    spec_c     = 1'b1;
    spec_dbz_c = 1'b0;
    spec_q_c   = NAN_OUT;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_q_c = NAN_OUT;
    end else if (a_inf) begin
      spec_q_c = {sign_c, 8'hFF, 7'h00};
    end else if (b_zero) begin
      spec_q_c   = {sign_c, 8'hFF, 7'h00};
      spec_dbz_c = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_q_c = {sign_c, 15'h0000};
    end else begin
      spec_c = 1'b0;
    end
  end

  // One restoring step: subtract when the divisor fits.
  logic       rem_ge_c;
  logic [8:0] rem_sub_c;

  assign rem_ge_c  = (rem_q >= {1'b0, mb_q});
  assign rem_sub_c = rem_ge_c ? (rem_q - {1'b0, mb_q}) : rem_q;

  // Normalise the quotient, apply optional rounding, then range-check the exponent.
  logic signed [9:0] exp_c;
  logic [6:0]        man_c;
  logic [15:0]       norm_q_c;
`ifdef DIVIDER_BF16_ROUND_EN
  logic              guard_c, sticky_c;
  logic [7:0]        man_r_c;
`endif

  always_comb begin
    exp_c = $signed(10'(ea_q)) - $signed(10'(eb_q)) + 10'sd127;
    if (quo_q[NQ-1]) begin
      man_c = quo_q[NQ-2 -: 7];
    end else begin
      man_c = quo_q[NQ-3 -: 7];
      exp_c = exp_c - 10'sd1;
    end
`ifdef DIVIDER_BF16_ROUND_EN
    // When the leading bit is set, quo_q[0] lies below the guard and joins the sticky.
    if (quo_q[NQ-1]) begin
      guard_c  = quo_q[1];
      sticky_c = quo_q[0] | (rem_q != 9'h000);
    end else begin
      guard_c  = quo_q[0];
      sticky_c = (rem_q != 9'h000);
    end
    man_r_c = {1'b0, man_c} + 8'(guard_c & (sticky_c | man_c[0]));
    if (man_r_c[7]) begin
      man_c = 7'h00;
      exp_c = exp_c + 10'sd1;
    end else begin
      man_c = man_r_c[6:0];
    end
`endif
    if (exp_c >= 10'sd255) begin
      norm_q_c = {sign_q, 8'hFF, 7'h00};
    end else if (exp_c <= 10'sd0) begin
      norm_q_c = {sign_q, 15'h0000};
    end else begin
      norm_q_c = {sign_q, exp_c[7:0], man_c};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      ea_q        <= 8'h00;
      eb_q        <= 8'h00;
      mb_q        <= 8'h00;
      rem_q       <= 9'h000;
      quo_q       <= '0;
      cnt_q       <= '0;
      q_q         <= 16'h0000;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= sign_c;
            ea_q       <= A[14:7];
            eb_q       <= B[14:7];
            mb_q       <= {1'b1, B[6:0]};
            rem_q      <= {2'b01, A[6:0]};
            quo_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (spec_c) begin
              q_q         <= spec_q_c;
              dbz_q       <= spec_dbz_c;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= DIV;
            end
          end
        end
        DIV: begin
          quo_q <= {quo_q[NQ-2:0], rem_ge_c};
          rem_q <= 9'(rem_sub_c << 1);
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(NQ - 1)) begin
            state_q <= NORM;
          end
        end
        NORM: begin
          q_q         <= norm_q_c;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
